// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60Hz raster timing constants shared by the controller and
// its per-axis counters. Each axis is ordered sync, back porch, active,
// front porch, starting from count 0.
package vga_timing_pkg;

    // Width of every raster counter and address (800 and 525 both fit).
    localparam int CNT_W = 10;

    // Horizontal timing, in pixel clocks.
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;

    // Vertical timing, in lines.
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;

    // Full period of one axis: sync + back porch + active + front porch.
    function automatic int axis_total(input int sync_len, input int bp_len,
                                      input int active_len, input int fp_len);
        return sync_len + bp_len + active_len + fp_len;
    endfunction

    localparam int H_TOTAL = axis_total(H_SYNC, H_BP, H_ACTIVE, H_FP);  // 800
    localparam int V_TOTAL = axis_total(V_SYNC, V_BP, V_ACTIVE, V_FP);  // 525

    // Active window per axis: start is inclusive, end is exclusive.
    localparam int H_ACT_START = H_SYNC + H_BP;            // 144
    localparam int H_ACT_END   = H_ACT_START + H_ACTIVE;   // 784
    localparam int V_ACT_START = V_SYNC + V_BP;            // 35
    localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;   // 515

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter with a count enable, plus
// the sync pulse, active-window flag and active-relative address decoded
// from it. Used once for columns (always enabled) and once for lines
// (enabled by the column counter's carry).
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int SYNC_LEN   = H_SYNC,
    parameter int BP_LEN     = H_BP,
    parameter int ACTIVE_LEN = H_ACTIVE,
    parameter int FP_LEN     = H_FP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             carry,
    output logic             sync_n,
    output logic             act,
    output logic [CNT_W-1:0] addr
);

    localparam int TOTAL = axis_total(SYNC_LEN, BP_LEN, ACTIVE_LEN, FP_LEN);

    localparam logic [CNT_W-1:0] LAST      = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] SYNC_END  = CNT_W'(SYNC_LEN);
    localparam logic [CNT_W-1:0] ACT_START = CNT_W'(SYNC_LEN + BP_LEN);
    localparam logic [CNT_W-1:0] ACT_END   = CNT_W'(SYNC_LEN + BP_LEN + ACTIVE_LEN);

    logic [CNT_W-1:0] cnt;

    // Position counter: advance when enabled, return to 0 after the last position.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Zero-latency decode of the registered position.
    // NOTE: every output gets a value on every path through this block, so no
    // latch can be inferred for any of them.
    always_comb begin
        carry  = en && (cnt == LAST);
        sync_n = (cnt >= SYNC_END);
        act    = (cnt >= ACT_START) && (cnt < ACT_END);
        addr   = '0;
        if (act) begin
            addr = cnt - ACT_START;
        end
    end

endmodule

// File: rtl/vga_ctrl.sv
// VGA raster timing generator and pixel gate. Produces hsync/vsync, the
// active-video flag and the current pixel coordinate; the frame memory
// returns that pixel's RGB combinationally on vga_data in the same cycle,
// and it is forced to black outside the visible area.
module vga_ctrl #(
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic [23:0] vga_data,
    output logic [9:0]  h_addr,
    output logic [9:0]  v_addr,
    output logic        hsync,
    output logic        vsync,
    output logic        valid,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b
);

    logic h_carry;
    logic h_act;
    logic v_act;
    logic v_carry_unused;  // end-of-frame strobe; nothing downstream needs it

    // Column counter: runs every pixel clock; its carry marks the end of a line.
    vga_axis_counter #(
        .SYNC_LEN   (H_SYNC),
        .BP_LEN     (H_BP),
        .ACTIVE_LEN (H_ACTIVE),
        .FP_LEN     (H_FP)
    ) u_h_axis (
        .clk    (pclk),
        .rst_n  (reset),
        .en     (1'b1),
        .carry  (h_carry),
        .sync_n (hsync),
        .act    (h_act),
        .addr   (h_addr)
    );

    // Line counter: steps once per line, so both axes wrap on the same edge
    // at the last pixel of the last line.
    vga_axis_counter #(
        .SYNC_LEN   (V_SYNC),
        .BP_LEN     (V_BP),
        .ACTIVE_LEN (V_ACTIVE),
        .FP_LEN     (V_FP)
    ) u_v_axis (
        .clk    (pclk),
        .rst_n  (reset),
        .en     (h_carry),
        .carry  (v_carry_unused),
        .sync_n (vsync),
        .act    (v_act),
        .addr   (v_addr)
    );

    // Pixel gate: pass the frame-memory colour only inside the visible area.
    always_comb begin
        valid = h_act & v_act;
        vga_r = 8'h00;
        vga_g = 8'h00;
        vga_b = 8'h00;
        if (valid) begin
            vga_r = vga_data[23:16];
            vga_g = vga_data[15:8];
            vga_b = vga_data[7:0];
        end
    end

endmodule

// File: tb/tb_vga_ctrl.sv
// Directed bench for vga_ctrl. The full-size instance covers reset, line
// timing, the first visible lines, the blanking gate and a mid-frame
// asynchronous reset. A second instance with a shrunken raster covers a
// whole frame, the last visible pixel and the simultaneous h/v wrap.
module tb_vga_ctrl;

    // Full 640x480 instance.
    logic        pclk;
    logic        reset;
    logic        blank_fill;
    logic [23:0] vga_data;
    logic [9:0]  h_addr, v_addr;
    logic        hsync, vsync, valid;
    logic [7:0]  vga_r, vga_g, vga_b;

    // Reduced raster instance: H 3/2/10/1 (16), V 2/1/4/2 (9), 144-cycle frame.
    logic        s_reset;
    logic [23:0] s_vga_data;
    logic [9:0]  s_h_addr, s_v_addr;
    logic        s_hsync, s_vsync, s_valid;
    logic [7:0]  s_vga_r, s_vga_g, s_vga_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame memory stand-in: colour encodes the requested address.
    assign vga_data   = blank_fill ? 24'hFFFFFF : {v_addr[7:0], h_addr[7:0], 8'h5A};
    assign s_vga_data = {s_v_addr[7:0], s_h_addr[7:0], 8'h5A};

    vga_ctrl u_dut (
        .pclk     (pclk),
        .reset    (reset),
        .vga_data (vga_data),
        .h_addr   (h_addr),
        .v_addr   (v_addr),
        .hsync    (hsync),
        .vsync    (vsync),
        .valid    (valid),
        .vga_r    (vga_r),
        .vga_g    (vga_g),
        .vga_b    (vga_b)
    );

    vga_ctrl #(
        .H_SYNC(3), .H_BP(2), .H_ACTIVE(10), .H_FP(1),
        .V_SYNC(2), .V_BP(1), .V_ACTIVE(4),  .V_FP(2)
    ) u_small (
        .pclk     (pclk),
        .reset    (s_reset),
        .vga_data (s_vga_data),
        .h_addr   (s_h_addr),
        .v_addr   (s_v_addr),
        .hsync    (s_hsync),
        .vsync    (s_vsync),
        .valid    (s_valid),
        .vga_r    (s_vga_r),
        .vga_g    (s_vga_g),
        .vga_b    (s_vga_b)
    );

    initial pclk = 1'b0;
    always #20 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_hsync"},  {31'd0, hsync},  32'd0);
        check({pfx, "_vsync"},  {31'd0, vsync},  32'd0);
        check({pfx, "_valid"},  {31'd0, valid},  32'd0);
        check({pfx, "_h_addr"}, {22'd0, h_addr}, 32'd0);
        check({pfx, "_v_addr"}, {22'd0, v_addr}, 32'd0);
        check({pfx, "_rgb"},    {8'd0, vga_r, vga_g, vga_b}, 32'd0);
    endtask

    initial begin
        int hs_low, vs_low, vld_cnt, blank_bad, first_valid, last_valid, last_fall;
        int zero_blank, ff_valid;
        logic prev_hs;
        logic [9:0]  fh, fv, lh, lv, l36h, l36v;
        logic [23:0] frgb, lrgb;
        logic hs95, hs96, w143_hs, w143_vs, w144_hs, w144_vs, w197_vld;
        logic [9:0] w197_h, w197_v;

        reset      = 1'b0;
        s_reset    = 1'b0;
        blank_fill = 1'b0;

        // Reset held for 5 cycles: everything at frame origin, both instances.
        repeat (5) @(negedge pclk);
        check_reset_outputs("rst");
        check("rst_small_sync", {30'd0, s_hsync, s_vsync}, 32'd0);

        // Release; c counts rising edges since release (h = c%800, v = c/800).
        reset = 1'b1;
        hs_low = 0; vs_low = 0; vld_cnt = 0; blank_bad = 0;
        first_valid = -1; last_valid = -1; last_fall = -1; prev_hs = 1'b1;
        fh = '0; fv = '0; lh = '0; lv = '0; frgb = '0; lrgb = '0;
        for (int c = 0; c < 36 * 800; c++) begin
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
            if (prev_hs && !hsync && first_valid < 0) last_fall = c;
            prev_hs = hsync;
            if (valid) begin
                vld_cnt++;
                if (first_valid < 0) begin
                    first_valid = c; fh = h_addr; fv = v_addr; frgb = {vga_r, vga_g, vga_b};
                end
                last_valid = c; lh = h_addr; lv = v_addr; lrgb = {vga_r, vga_g, vga_b};
            end else if ({vga_r, vga_g, vga_b} != 24'h0) begin
                blank_bad++;
            end
            @(negedge pclk);
        end
        // Lines 0..35: 36 hsync pulses, one 2-line vsync, only line 35 visible.
        check("hsync_low_36_lines", hs_low, 32'd3456);
        check("vsync_low_cycles",   vs_low, 32'd1600);
        check("valid_count_line35", vld_cnt, 32'd640);
        check("first_valid_cycle",  first_valid, 32'd28144);
        check("last_valid_cycle",   last_valid, 32'd28783);
        check("hsync_fall_to_valid", first_valid - last_fall, 32'd144);
        check("first_px_h_addr", {22'd0, fh}, 32'd0);
        check("first_px_v_addr", {22'd0, fv}, 32'd0);
        check("first_px_rgb",    {8'd0, frgb}, 32'h00005A);
        check("line35_last_h_addr", {22'd0, lh}, 32'd639);
        check("line35_last_v_addr", {22'd0, lv}, 32'd0);
        check("line35_last_rgb",    {8'd0, lrgb}, 32'h007F5A);
        check("blank_rgb_nonzero",  blank_bad, 32'd0);

        // Line 36 with all-ones frame data: porches must still come out black.
        blank_fill = 1'b1;
        zero_blank = 0; ff_valid = 0; l36h = '1; l36v = '1;
        for (int c = 0; c < 800; c++) begin
            if (!valid && {vga_r, vga_g, vga_b} == 24'h0) zero_blank++;
            if (valid && {vga_r, vga_g, vga_b} == 24'hFFFFFF) ff_valid++;
            if (c == 144) begin l36h = h_addr; l36v = v_addr; end
            @(negedge pclk);
        end
        blank_fill = 1'b0;
        check("gate_blank_black", zero_blank, 32'd160);
        check("gate_active_pass", ff_valid, 32'd640);
        check("line36_first_h_addr", {22'd0, l36h}, 32'd0);
        check("line36_first_v_addr", {22'd0, l36v}, 32'd1);

        // Move to line 40, column 300 (c = 32300; now at c = 29600).
        repeat (2700) @(negedge pclk);
        check("pre_reset_valid",  {31'd0, valid},  32'd1);
        check("pre_reset_h_addr", {22'd0, h_addr}, 32'd156);
        check("pre_reset_v_addr", {22'd0, v_addr}, 32'd5);

        // Asynchronous reset between clock edges: outputs drop immediately.
        #5 reset = 1'b0;
        #1 check_reset_outputs("async_rst");
        repeat (3) @(negedge pclk);
        reset = 1'b1;

        // Timing restarts from the frame origin.
        hs_low = 0; vs_low = 0; vld_cnt = 0; hs95 = 1'bx; hs96 = 1'bx;
        for (int c = 0; c < 1610; c++) begin
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
            if (valid) vld_cnt++;
            if (c == 95) hs95 = hsync;
            if (c == 96) hs96 = hsync;
            @(negedge pclk);
        end
        check("restart_hsync_low", hs_low, 32'd202);
        check("restart_vsync_low", vs_low, 32'd1600);
        check("restart_valid",     vld_cnt, 32'd0);
        check("restart_hsync_c95", {31'd0, hs95}, 32'd0);
        check("restart_hsync_c96", {31'd0, hs96}, 32'd1);

        // Reduced raster: one complete frame plus the wrap into the next.
        s_reset = 1'b1;
        hs_low = 0; vs_low = 0; vld_cnt = 0; blank_bad = 0;
        first_valid = -1; last_valid = -1;
        w143_hs = 1'bx; w143_vs = 1'bx; w144_hs = 1'bx; w144_vs = 1'bx;
        w197_vld = 1'bx; w197_h = 'x; w197_v = 'x;
        for (int c = 0; c < 198; c++) begin
            if (c < 144) begin
                if (!s_hsync) hs_low++;
                if (!s_vsync) vs_low++;
                if (s_valid) begin
                    vld_cnt++;
                    if (first_valid < 0) begin
                        first_valid = c; fh = s_h_addr; fv = s_v_addr;
                        frgb = {s_vga_r, s_vga_g, s_vga_b};
                    end
                    last_valid = c; lh = s_h_addr; lv = s_v_addr;
                    lrgb = {s_vga_r, s_vga_g, s_vga_b};
                end else if ({s_vga_r, s_vga_g, s_vga_b} != 24'h0) begin
                    blank_bad++;
                end
            end
            if (c == 143) begin w143_hs = s_hsync; w143_vs = s_vsync; end
            if (c == 144) begin w144_hs = s_hsync; w144_vs = s_vsync; end
            if (c == 197) begin w197_vld = s_valid; w197_h = s_h_addr; w197_v = s_v_addr; end
            @(negedge pclk);
        end
        check("sm_hsync_low", hs_low, 32'd27);
        check("sm_vsync_low", vs_low, 32'd32);
        check("sm_valid_count", vld_cnt, 32'd40);
        check("sm_first_valid", first_valid, 32'd53);
        check("sm_last_valid",  last_valid, 32'd110);
        check("sm_first_rgb",   {8'd0, frgb}, 32'h00005A);
        check("sm_first_addr",  {12'd0, fv, fh}, 32'd0);
        check("sm_last_h_addr", {22'd0, lh}, 32'd9);
        check("sm_last_v_addr", {22'd0, lv}, 32'd3);
        check("sm_last_rgb",    {8'd0, lrgb}, 32'h03095A);
        check("sm_blank_rgb",   blank_bad, 32'd0);
        check("sm_wrap_before", {30'd0, w143_hs, w143_vs}, 32'd3);
        check("sm_wrap_after",  {30'd0, w144_hs, w144_vs}, 32'd0);
        check("sm_frame2_first_valid", {31'd0, w197_vld}, 32'd1);
        check("sm_frame2_first_addr",  {12'd0, w197_v, w197_h}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
